// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-back, write-allocate data cache with SETS lines of
// 32 bytes each. Loads and stores that hit complete combinationally in the
// cycle they are presented. Misses evict the victim line if it is dirty
// (WRITEBACK), then fetch the requested block (FILL). The core retries the
// same request until data_valid_fDC rises. A flush writes every dirty line
// back in index order, then invalidates the whole cache.
//
// Ports
//   CLK                    sole clock, rising edge
//   RESET                  asynchronous active-low reset
//   data_address_2DC       core byte address
//   read_2DC / write_2DC   load / store request (both high = store)
//   data_write_2DC         store data (right-justified, n LS bytes used)
//   data_write_size_2DC    store byte count 1..3, 0 means 4
//   flush_2DC              write back and invalidate all lines
//   data_read_fDC          aligned 32-bit load word
//   data_valid_fDC         core request completes this cycle
//   flush_done             flush finished, held until flush_2DC drops
//   data_address_2DM       block address to memory, bits [4:0] = 0
//   dBlkRead / dBlkWrite   block fill / writeback request
//   block_write_2DM        writeback block data
//   block_read_fDM         fill block data
//   block_read_fDM_valid   fill acknowledge
//   block_write_fDM_valid  writeback acknowledge
// ---------------------------------------------------------------------------
module data_cache #(
  parameter int SETS = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DC,
  input  logic         read_2DC,
  input  logic         write_2DC,
  input  logic [31:0]  data_write_2DC,
  input  logic [1:0]   data_write_size_2DC,
  input  logic         flush_2DC,
  output logic [31:0]  data_read_fDC,
  output logic         data_valid_fDC,
  output logic         flush_done,
  output logic [31:0]  data_address_2DM,
  output logic         dBlkRead,
  output logic         dBlkWrite,
  output logic [255:0] block_write_2DM,
  input  logic [255:0] block_read_fDM,
  input  logic         block_read_fDM_valid,
  input  logic         block_write_fDM_valid
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    FILL,
    FLUSH,
    FLUSH_DONE
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Per-line status bits need a reset; tags and data do not, because a line
  // is never looked at unless its valid bit is set.
  logic [SETS-1:0]  valid_reg;
  logic [SETS-1:0]  dirty_reg;
  logic [IDX_W-1:0] flush_idx_reg;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [255:0]     data_mem [SETS];

  // ---------------------------------------------------------------------
  // Address decode and line lookup
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word_sel;
  logic [1:0]       byte_off;
  logic [7:0]       word_lsb;

  assign req_idx  = data_address_2DC[5 +: IDX_W];
  assign req_tag  = data_address_2DC[31 -: TAG_W];
  assign word_sel = data_address_2DC[4:2];
  assign byte_off = data_address_2DC[1:0];
  assign word_lsb = {word_sel, 5'b00000};

  logic             line_valid;
  logic             line_dirty;
  logic [TAG_W-1:0] line_tag;
  logic [255:0]     line_data;
  logic             hit;

  assign line_valid = valid_reg[req_idx];
  assign line_dirty = dirty_reg[req_idx];
  assign line_tag   = tag_mem[req_idx];
  assign line_data  = data_mem[req_idx];
  assign hit        = line_valid && (line_tag == req_tag);

  // Line currently visited by the flush walk
  logic             fl_valid;
  logic             fl_dirty;
  logic [TAG_W-1:0] fl_tag;
  logic [255:0]     fl_data;

  assign fl_valid = valid_reg[flush_idx_reg];
  assign fl_dirty = dirty_reg[flush_idx_reg];
  assign fl_tag   = tag_mem[flush_idx_reg];
  assign fl_data  = data_mem[flush_idx_reg];

  // ---------------------------------------------------------------------
  // Big-endian store merge. Byte lane p of the word sits at bits
  // [31-8p -: 8]. Lanes byte_off .. byte_off+n-1 are written; lane p takes
  // store byte (byte_off+n-1-p), so the last lane written receives the
  // least-significant byte of data_write_2DC.
  // ---------------------------------------------------------------------
  logic [3:0]   store_bytes;
  logic [3:0]   lane_lo;
  logic [3:0]   lane_hi;
  logic [31:0]  old_word;
  logic [31:0]  merged_word;
  logic [255:0] store_line;

  assign store_bytes = (data_write_size_2DC == 2'd0) ? 4'd4 : {2'b00, data_write_size_2DC};
  assign lane_lo     = {2'b00, byte_off};
  assign lane_hi     = lane_lo + store_bytes;
  assign old_word    = line_data[word_lsb +: 32];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_en;
      logic [1:0] src;
      assign lane_en = (4'(gi) >= lane_lo) && (4'(gi) < lane_hi);
      assign src     = 2'(lane_hi - 4'd1 - 4'(gi));
      assign merged_word[8*(3-gi) +: 8] = lane_en ? data_write_2DC[{src, 3'b000} +: 8]
                                                  : old_word[8*(3-gi) +: 8];
    end
  endgenerate

  always_comb begin
    store_line = line_data;
    store_line[word_lsb +: 32] = merged_word;
  end

  // ---------------------------------------------------------------------
  // Event decode shared by the FSM and datapath
  // ---------------------------------------------------------------------
  logic core_req;
  logic idle_req;
  logic store_hit;
  logic wb_done;
  logic fill_done;
  logic flush_need_wb;
  logic flush_step;

  assign core_req      = read_2DC || write_2DC;
  assign idle_req      = (state_reg == IDLE) && !flush_2DC && core_req;
  assign store_hit     = idle_req && hit && write_2DC;
  assign wb_done       = (state_reg == WRITEBACK) && block_write_fDM_valid;
  assign fill_done     = (state_reg == FILL) && block_read_fDM_valid;
  assign flush_need_wb = fl_valid && fl_dirty;
  // A clean line is skipped in one cycle; a dirty one waits for its ack.
  assign flush_step    = (state_reg == FLUSH) && (!flush_need_wb || block_write_fDM_valid);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (flush_2DC) begin
          state_next = FLUSH;
        end else if (core_req && !hit) begin
          state_next = (line_valid && line_dirty) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (block_write_fDM_valid) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (block_read_fDM_valid) begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        if (flush_step && (flush_idx_reg == LAST_IDX)) begin
          state_next = FLUSH_DONE;
        end
      end
      FLUSH_DONE: begin
        if (!flush_2DC) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Everything is forced low while RESET is asserted so a
  // reset mid-transfer drops the memory request immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    data_read_fDC    = 32'd0;
    data_valid_fDC   = 1'b0;
    flush_done       = 1'b0;
    data_address_2DM = 32'd0;
    dBlkRead         = 1'b0;
    dBlkWrite        = 1'b0;
    block_write_2DM  = 256'd0;
    if (RESET) begin
      case (state_reg)
        IDLE: begin
          if (idle_req && hit) begin
            data_valid_fDC = 1'b1;
            if (!write_2DC) begin
              data_read_fDC = line_data[word_lsb +: 32];
            end
          end
        end
        WRITEBACK: begin
          dBlkWrite        = 1'b1;
          data_address_2DM = {line_tag, req_idx, 5'b00000};
          block_write_2DM  = line_data;
        end
        FILL: begin
          dBlkRead         = 1'b1;
          data_address_2DM = {req_tag, req_idx, 5'b00000};
        end
        FLUSH: begin
          if (flush_need_wb) begin
            dBlkWrite        = 1'b1;
            data_address_2DM = {fl_tag, flush_idx_reg, 5'b00000};
            block_write_2DM  = fl_data;
          end
        end
        FLUSH_DONE: begin
          flush_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Line status bits and flush walk index
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_reg     <= '0;
      dirty_reg     <= '0;
      flush_idx_reg <= '0;
    end else begin
      if (store_hit) begin
        dirty_reg[req_idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_reg[req_idx] <= 1'b0;
      end
      if (fill_done) begin
        valid_reg[req_idx] <= 1'b1;
        dirty_reg[req_idx] <= 1'b0;
      end
      if (flush_step) begin
        // Index wraps back to 0 after the last line, ready for the next flush.
        flush_idx_reg <= flush_idx_reg + 1'b1;
        if (flush_need_wb) begin
          dirty_reg[flush_idx_reg] <= 1'b0;
        end
        if (flush_idx_reg == LAST_IDX) begin
          valid_reg <= '0;
          dirty_reg <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Tag and data arrays: one write port, written either by a fill or by a
  // store hit (never both in the same cycle since they live in different
  // states).
  // ---------------------------------------------------------------------
  logic         line_we;
  logic [255:0] line_wdata;

  assign line_we    = RESET && (store_hit || fill_done);
  assign line_wdata = fill_done ? block_read_fDM : store_line;

  always_ff @(posedge CLK) begin
    if (line_we) begin
      data_mem[req_idx] <= line_wdata;
    end
    if (RESET && fill_done) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// ---------------------------------------------------------------------------
// tb_data_cache
//
// Self-checking bench for data_cache. A behavioural memory answers block
// reads/writes after a programmable latency and logs every bus transfer.
// A word-level reference model tracks what the core should observe; load
// expectations are queued when a request is driven and popped when the
// cache reports data_valid_fDC.
// ---------------------------------------------------------------------------
module tb_data_cache;
  localparam int SETS = 32;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [31:0]  data_address_2DC = '0;
  logic         read_2DC = 1'b0;
  logic         write_2DC = 1'b0;
  logic [31:0]  data_write_2DC = '0;
  logic [1:0]   data_write_size_2DC = '0;
  logic         flush_2DC = 1'b0;
  logic [31:0]  data_read_fDC;
  logic         data_valid_fDC;
  logic         flush_done;
  logic [31:0]  data_address_2DM;
  logic         dBlkRead;
  logic         dBlkWrite;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM = '0;
  logic         block_read_fDM_valid = 1'b0;
  logic         block_write_fDM_valid = 1'b0;

  data_cache #(.SETS(SETS)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .data_address_2DC      (data_address_2DC),
    .read_2DC              (read_2DC),
    .write_2DC             (write_2DC),
    .data_write_2DC        (data_write_2DC),
    .data_write_size_2DC   (data_write_size_2DC),
    .flush_2DC             (flush_2DC),
    .data_read_fDC         (data_read_fDC),
    .data_valid_fDC        (data_valid_fDC),
    .flush_done            (flush_done),
    .data_address_2DM      (data_address_2DM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit           is_write;
    logic [31:0]  addr;
    logic [255:0] data;
  } bus_t;

  logic [31:0]  exp_q[$];
  bus_t         bus_log[$];
  logic [255:0] mem_blk [bit [31:0]];
  logic [31:0]  gold [bit [31:0]];

  int  mem_lat = 1;
  bit  mem_en = 1'b1;
  int  n_fills = 0;
  bit  both_seen = 1'b0;
  int  last_cycles = 0;
  logic [31:0] last_rdata = '0;

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (gold.exists(wa)) return gold[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] ref_block(input logic [31:0] ba);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[32*w +: 32] = ref_word(ba + 32'(4*w));
    return b;
  endfunction

  function automatic logic [255:0] backing_block(input logic [31:0] ba);
    logic [255:0] b;
    if (mem_blk.exists(ba)) return mem_blk[ba];
    for (int w = 0; w < 8; w++) b[32*w +: 32] = init_word(ba + 32'(4*w));
    return b;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    int b;
    logic [31:0] word;
    n = (sz == 2'd0) ? 4 : int'(sz);
    b = int'(a[1:0]);
    word = ref_word(a);
    for (int k = 0; k < n; k++) word[31 - 8*(b+k) -: 8] = d[8*(n-1-k) +: 8];
    gold[{a[31:2], 2'b00}] = word;
  endtask

  // -------------------------------------------------------------------------
  // Behavioural memory
  // -------------------------------------------------------------------------
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        cnt = 0;
        block_read_fDM_valid = 1'b0;
        block_write_fDM_valid = 1'b0;
      end else if (block_read_fDM_valid || block_write_fDM_valid) begin
        block_read_fDM_valid = 1'b0;
        block_write_fDM_valid = 1'b0;
        cnt = 0;
      end else if (mem_en && (dBlkRead || dBlkWrite)) begin
        cnt++;
        if (cnt >= mem_lat) begin
          if (dBlkWrite) begin
            bus_log.push_back(bus_t'{1'b1, data_address_2DM, block_write_2DM});
            mem_blk[data_address_2DM] = block_write_2DM;
            block_write_fDM_valid = 1'b1;
          end else begin
            block_read_fDM = backing_block(data_address_2DM);
            bus_log.push_back(bus_t'{1'b0, data_address_2DM, block_read_fDM});
            n_fills++;
            block_read_fDM_valid = 1'b1;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (dBlkRead && dBlkWrite) both_seen = 1'b1;
  end

  // -------------------------------------------------------------------------
  // One core request, retried until data_valid_fDC
  // -------------------------------------------------------------------------
  task automatic core_access(input logic [31:0] a, input bit rd, input bit wr,
                             input logic [31:0] d, input logic [1:0] sz, input string name);
    bit is_load;
    bit got;
    int cyc;
    logic [31:0] exp;
    is_load = rd && !wr;
    got = 1'b0;
    cyc = 0;
    @(posedge CLK);
    #1;
    data_address_2DC = a;
    read_2DC = rd;
    write_2DC = wr;
    data_write_2DC = d;
    data_write_size_2DC = sz;
    if (is_load) exp_q.push_back(ref_word(a));
    else ref_store(a, d, sz);
    while (cyc < 200 && !got) begin
      @(negedge CLK);
      cyc++;
      if (data_valid_fDC) got = 1'b1;
    end
    last_cycles = cyc;
    last_rdata = data_read_fDC;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: data_valid_fDC still 0 after %0d cycles, required 1", name, cyc);
      exp_q.delete();
    end else if (is_load) begin
      exp = exp_q.pop_front();
      total++;
      if (data_read_fDC !== exp) begin
        bad++;
        $display("FAIL %s data: got %h required %h", name, data_read_fDC, exp);
      end
    end
    $display("txn %s %s addr=%h wdata=%h size=%0d rdata=%h cycles=%0d",
             name, is_load ? "load " : "store", a, d, sz, data_read_fDC, cyc);
    @(posedge CLK);
    #1;
    read_2DC = 1'b0;
    write_2DC = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    RESET = 1'b0;
    read_2DC = 1'b1;
    flush_2DC = 1'b1;
    data_address_2DC = 32'h100;
    repeat (2) @(negedge CLK);
    total++; if (data_valid_fDC !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", data_valid_fDC); end
    total++; if (dBlkRead !== 1'b0) begin bad++; $display("FAIL reset_blkread: got %b required 0", dBlkRead); end
    total++; if (dBlkWrite !== 1'b0) begin bad++; $display("FAIL reset_blkwrite: got %b required 0", dBlkWrite); end
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL reset_flush_done: got %b required 0", flush_done); end
    total++; if (data_address_2DM !== 32'd0) begin bad++; $display("FAIL reset_addr: got %h required 0", data_address_2DM); end
    total++; if (block_write_2DM !== 256'd0) begin bad++; $display("FAIL reset_wdata: got %h required 0", block_write_2DM); end
    total++; if (data_read_fDC !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h required 0", data_read_fDC); end
    read_2DC = 1'b0;
    flush_2DC = 1'b0;
    RESET = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_first_load();
    logic [255:0] b;
    logic [31:0] exp;
    mem_lat = 1;
    gold[32'h100] = 32'hDEADBEEF;
    b = backing_block(32'h100);
    b[31:0] = 32'hDEADBEEF;
    mem_blk[32'h100] = b;
    @(posedge CLK);
    #1;
    data_address_2DC = 32'h100;
    read_2DC = 1'b1;
    exp_q.push_back(ref_word(32'h100));
    @(negedge CLK);
    total++; if (data_valid_fDC !== 1'b0) begin bad++; $display("FAIL first_miss_valid: got %b required 0", data_valid_fDC); end
    @(negedge CLK);
    total++; if (dBlkRead !== 1'b1) begin bad++; $display("FAIL first_blkread: got %b required 1", dBlkRead); end
    total++; if (data_address_2DM !== 32'h100) begin bad++; $display("FAIL first_fill_addr: got %h required 00000100", data_address_2DM); end
    total++; if (data_valid_fDC !== 1'b0) begin bad++; $display("FAIL first_fill_valid: got %b required 0", data_valid_fDC); end
    @(negedge CLK);
    total++; if (data_valid_fDC !== 1'b1) begin bad++; $display("FAIL first_hit_valid: got %b required 1", data_valid_fDC); end
    exp = exp_q.pop_front();
    total++; if (data_read_fDC !== exp) begin bad++; $display("FAIL first_hit_data: got %h required %h", data_read_fDC, exp); end
    total++; if (data_read_fDC !== 32'hDEADBEEF) begin bad++; $display("FAIL first_hit_const: got %h required deadbeef", data_read_fDC); end
    $display("txn first_load load  addr=00000100 rdata=%h", data_read_fDC);
    @(posedge CLK);
    #1;
    read_2DC = 1'b0;
  endtask

  task automatic test_store_hit();
    core_access(32'h101, 1'b0, 1'b1, 32'h0000_00AB, 2'd1, "store_byte");
    total++; if (last_cycles !== 1) begin bad++; $display("FAIL store_hit_latency: got %0d cycles required 1", last_cycles); end
    core_access(32'h100, 1'b1, 1'b0, 32'h0, 2'd0, "load_merged");
    total++; if (last_rdata !== 32'hDEABBEEF) begin bad++; $display("FAIL merged_const: got %h required deabbeef", last_rdata); end
  endtask

  task automatic test_conflict();
    logic [255:0] exp_blk;
    bus_log.delete();
    both_seen = 1'b0;
    mem_lat = 2;
    exp_blk = ref_block(32'h100);
    core_access(32'h100 + 32'(32*SETS), 1'b1, 1'b0, 32'h0, 2'd0, "conflict_load");
    total++; if (bus_log.size() !== 2) begin bad++; $display("FAIL conflict_ops: got %0d bus transfers required 2", bus_log.size()); end
    if (bus_log.size() >= 2) begin
      total++; if (bus_log[0].is_write !== 1'b1) begin bad++; $display("FAIL conflict_first_kind: got write=%b required 1", bus_log[0].is_write); end
      total++; if (bus_log[0].addr !== 32'h100) begin bad++; $display("FAIL conflict_wb_addr: got %h required 00000100", bus_log[0].addr); end
      total++; if (bus_log[0].data !== exp_blk) begin bad++; $display("FAIL conflict_wb_data: got %h required %h", bus_log[0].data, exp_blk); end
      total++; if (bus_log[0].data[31:0] !== 32'hDEABBEEF) begin bad++; $display("FAIL conflict_wb_word0: got %h required deabbeef", bus_log[0].data[31:0]); end
      total++; if (bus_log[1].is_write !== 1'b0) begin bad++; $display("FAIL conflict_second_kind: got write=%b required 0", bus_log[1].is_write); end
      total++; if (bus_log[1].addr !== 32'h100 + 32'(32*SETS)) begin bad++; $display("FAIL conflict_fill_addr: got %h required %h", bus_log[1].addr, 32'h100 + 32'(32*SETS)); end
    end
    total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL conflict_both_high: got %b required 0", both_seen); end
  endtask

  task automatic test_flush();
    int cyc;
    int fills_before;
    logic [255:0] exp0;
    logic [255:0] exp1;
    core_access(32'h06C, 1'b0, 1'b1, 32'h0000_1234, 2'd2, "dirty_a");
    core_access(32'h241, 1'b0, 1'b1, 32'h0000_5678, 2'd2, "dirty_b");
    exp0 = ref_block(32'h060);
    exp1 = ref_block(32'h240);
    bus_log.delete();
    @(posedge CLK);
    #1;
    flush_2DC = 1'b1;
    cyc = 0;
    while (cyc < 2000 && flush_done !== 1'b1) begin
      @(negedge CLK);
      cyc++;
    end
    total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL flush_done_rise: got %b required 1", flush_done); end
    total++; if (bus_log.size() !== 2) begin bad++; $display("FAIL flush_wb_count: got %0d required 2", bus_log.size()); end
    if (bus_log.size() >= 2) begin
      total++; if (bus_log[0].addr !== 32'h060 || bus_log[0].is_write !== 1'b1) begin bad++; $display("FAIL flush_wb0_addr: got %h write=%b required 00000060 write=1", bus_log[0].addr, bus_log[0].is_write); end
      total++; if (bus_log[0].data !== exp0) begin bad++; $display("FAIL flush_wb0_data: got %h required %h", bus_log[0].data, exp0); end
      total++; if (bus_log[1].addr !== 32'h240 || bus_log[1].is_write !== 1'b1) begin bad++; $display("FAIL flush_wb1_addr: got %h write=%b required 00000240 write=1", bus_log[1].addr, bus_log[1].is_write); end
      total++; if (bus_log[1].data !== exp1) begin bad++; $display("FAIL flush_wb1_data: got %h required %h", bus_log[1].data, exp1); end
    end
    $display("txn flush cycles=%0d writebacks=%0d", cyc, bus_log.size());
    @(posedge CLK);
    #1;
    flush_2DC = 1'b0;
    @(negedge CLK);
    total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL flush_done_hold: got %b required 1", flush_done); end
    @(negedge CLK);
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL flush_done_drop: got %b required 0", flush_done); end
    fills_before = n_fills;
    core_access(32'h100, 1'b1, 1'b0, 32'h0, 2'd0, "after_flush");
    total++; if (n_fills !== fills_before + 1) begin bad++; $display("FAIL after_flush_miss: got %0d fills required %0d", n_fills - fills_before, 1); end
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    int fills_before;
    mem_en = 1'b0;
    @(posedge CLK);
    #1;
    data_address_2DC = 32'h300;
    read_2DC = 1'b1;
    cyc = 0;
    while (cyc < 20 && dBlkRead !== 1'b1) begin
      @(negedge CLK);
      cyc++;
    end
    total++; if (dBlkRead !== 1'b1) begin bad++; $display("FAIL midfill_request: got %b required 1", dBlkRead); end
    #2;
    RESET = 1'b0;
    #1;
    total++; if (dBlkRead !== 1'b0) begin bad++; $display("FAIL midfill_drop_read: got %b required 0", dBlkRead); end
    total++; if (dBlkWrite !== 1'b0) begin bad++; $display("FAIL midfill_drop_write: got %b required 0", dBlkWrite); end
    total++; if (data_address_2DM !== 32'd0) begin bad++; $display("FAIL midfill_addr: got %h required 0", data_address_2DM); end
    $display("txn reset asserted during fill");
    read_2DC = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    mem_en = 1'b1;
    fills_before = n_fills;
    core_access(32'h100, 1'b1, 1'b0, 32'h0, 2'd0, "post_reset_load");
    total++; if (n_fills !== fills_before + 1) begin bad++; $display("FAIL post_reset_miss: got %0d fills required 1", n_fills - fills_before); end
    core_access(32'h300, 1'b1, 1'b0, 32'h0, 2'd0, "post_reset_other");
  endtask

  task automatic test_both_high();
    core_access(32'h104, 1'b1, 1'b1, 32'h1122_3344, 2'd0, "both_high");
    core_access(32'h104, 1'b1, 1'b0, 32'h0, 2'd0, "both_high_check");
    total++; if (last_rdata !== 32'h1122_3344) begin bad++; $display("FAIL both_high_word1: got %h required 11223344", last_rdata); end
    core_access(32'h100, 1'b1, 1'b0, 32'h0, 2'd0, "both_high_word0");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0] sz;
    int n;
    both_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      mem_lat = int'($urandom_range(1, 3));
      a = 32'($urandom_range(0, 3)) * 32'(32*SETS) + 32'($urandom_range(1, 2)) * 32'h20
          + 32'($urandom_range(0, 7)) * 32'd4;
      if ($urandom_range(0, 1) == 1) begin
        sz = 2'($urandom_range(0, 3));
        n = (sz == 2'd0) ? 4 : int'(sz);
        a[1:0] = 2'($urandom_range(0, 4 - n));
        core_access(a, 1'($urandom_range(0, 1)), 1'b1, $urandom, sz, "b2b_store");
      end else begin
        core_access(a, 1'b1, 1'b0, 32'h0, 2'd0, "b2b_load");
      end
    end
    total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL b2b_both_high: got %b required 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_store_hit();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_both_high();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule
